// File: rtl/debounce_pkg.sv
// Shared types, width helper and default parameter values for the debounce bank.
// Imported by debounce_channel and debounce_bank.
package debounce_pkg;

   localparam int DEF_N_CH          = 4;
   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_STABLE_CYCLES = 64;
   localparam int DEF_HOLD_CYCLES   = 50000000;
   localparam int DEF_REPEAT_EN     = 0;
   localparam int DEF_REPEAT_CYCLES = 10000000;

   typedef enum logic [1:0] {
      HS_IDLE,
      HS_WAIT_HOLD,
      HS_HELD
   } hold_state_t;

   // Bits needed to hold values 0..x, never less than one bit.
   function automatic int cnt_w(input int x);
      return (x < 1) ? 1 : $clog2(x + 1);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: input synchroniser, stable-window counter and the
// long-press / auto-repeat state machine. All outputs come straight from flops.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int REPEAT_EN     = DEF_REPEAT_EN,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_state,
   output logic o_down,
   output logic o_up,
   output logic o_hold,
   output logic o_repeat
);

   localparam int SC_W   = cnt_w(STABLE_CYCLES);
   localparam int HC_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int HC_W   = cnt_w(HC_MAX);
   localparam logic [SC_W-1:0] SC_LAST   = SC_W'(STABLE_CYCLES - 1);
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
   localparam logic [HC_W-1:0] REP_LAST  = HC_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [SC_W-1:0]        r_sc;
   logic                   r_state;
   logic                   r_down;
   logic                   r_up;
   logic                   r_hold;
   logic                   r_repeat;
   hold_state_t            r_hs;
   hold_state_t            w_hs_next;
   logic [HC_W-1:0]        r_hc;
   logic [HC_W-1:0]        w_hc_next;
   logic                   w_hold_next;
   logic                   w_repeat_next;
   logic                   w_s;
   logic                   w_differ;
   logic                   w_flip;
   logic                   w_down_ev;
   logic                   w_up_ev;

   assign w_s       = r_sync[SYNC_STAGES-1];
   assign w_differ  = (w_s != r_state);
   assign w_flip    = w_differ && (r_sc == SC_LAST);
   assign w_down_ev = w_flip && w_s;
   assign w_up_ev   = w_flip && !w_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync  <= '0;
         r_sc    <= '0;
         r_state <= 1'b0;
         r_down  <= 1'b0;
         r_up    <= 1'b0;
      end else begin
         r_sync[0] <= i_btn;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            r_sync[k] <= r_sync[k-1];
         end
         r_down <= w_down_ev;
         r_up   <= w_up_ev;
         // Any sample matching the current level restarts the window.
         if (!w_differ) begin
            r_sc <= '0;
         end else if (w_flip) begin
            r_sc    <= '0;
            r_state <= w_s;
         end else begin
            r_sc <= r_sc + SC_W'(1);
         end
      end
   end

   always_comb begin
      w_hs_next     = r_hs;
      w_hc_next     = r_hc;
      w_hold_next   = 1'b0;
      w_repeat_next = 1'b0;
      if (HOLD_CYCLES == 0) begin
         w_hs_next = HS_IDLE;
         w_hc_next = '0;
      end else if (w_down_ev) begin
         w_hs_next = HS_WAIT_HOLD;
         w_hc_next = '0;
      end else if (w_up_ev || !r_state) begin
         // A release on the same edge as a hold/repeat suppresses that pulse.
         w_hs_next = HS_IDLE;
         w_hc_next = '0;
      end else begin
         case (r_hs)
            HS_WAIT_HOLD: begin
               if (r_hc == HOLD_LAST) begin
                  w_hs_next   = HS_HELD;
                  w_hc_next   = '0;
                  w_hold_next = 1'b1;
               end else begin
                  w_hc_next = r_hc + HC_W'(1);
               end
            end
            HS_HELD: begin
               if (REPEAT_EN != 0) begin
                  if (r_hc == REP_LAST) begin
                     w_hc_next     = '0;
                     w_repeat_next = 1'b1;
                  end else begin
                     w_hc_next = r_hc + HC_W'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hs     <= HS_IDLE;
         r_hc     <= '0;
         r_hold   <= 1'b0;
         r_repeat <= 1'b0;
      end else begin
         r_hs     <= w_hs_next;
         r_hc     <= w_hc_next;
         r_hold   <= w_hold_next;
         r_repeat <= w_repeat_next;
      end
   end

   assign o_state  = r_state;
   assign o_down   = r_down;
   assign o_up     = r_up;
   assign o_hold   = r_hold;
   assign o_repeat = r_repeat;

endmodule

// File: rtl/debounce_bank.sv
// N independent debounce channels between raw board pins and control logic.
// Each bit of every port belongs to exactly one debounce_channel instance.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int N_CH          = DEF_N_CH,
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int REPEAT_EN     = DEF_REPEAT_EN,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] btn_state,
   output logic [N_CH-1:0] btn_down,
   output logic [N_CH-1:0] btn_up,
   output logic [N_CH-1:0] btn_hold,
   output logic [N_CH-1:0] btn_repeat
);

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         debounce_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_EN    (REPEAT_EN),
            .REPEAT_CYCLES(REPEAT_CYCLES)
         ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_btn   (btn_in[gi]),
            .o_state (btn_state[gi]),
            .o_down  (btn_down[gi]),
            .o_up    (btn_up[gi]),
            .o_hold  (btn_hold[gi]),
            .o_repeat(btn_repeat[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench: a timestamp-based reference model predicts every cycle's outputs for
// two banks sharing one stimulus (hold/repeat enabled, and hold disabled).
module tb_debounce_bank;

   localparam int SYNC   = 2;
   localparam int STABLE = 4;
   localparam int REP    = 5;

   typedef struct packed {
      logic [3:0] st;
      logic [3:0] dn;
      logic [3:0] up;
      logic [3:0] hd;
      logic [3:0] rp;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] btn_in;
   logic [1:0] a_state, a_down, a_up, a_hold, a_rep;
   logic [1:0] b_state, b_down, b_up, b_hold, b_rep;

   int   n_chk = 0;
   int   n_fail = 0;
   obs_t exp_q[$];
   int   c_dn[4], c_up[4], c_hd[4], c_rp[4];

   // Lanes 0,1 = bank A ch0/ch1; lanes 2,3 = bank B ch0/ch1.
   int   m_hold[4]   = '{20, 20, 0, 0};
   int   m_rep_en[4] = '{1, 1, 0, 0};

   always #5 clk = ~clk;

   debounce_bank #(
      .N_CH(2), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE),
      .HOLD_CYCLES(20), .REPEAT_EN(1), .REPEAT_CYCLES(REP)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
      .btn_state(a_state), .btn_down(a_down), .btn_up(a_up),
      .btn_hold(a_hold), .btn_repeat(a_rep)
   );

   debounce_bank #(
      .N_CH(2), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE),
      .HOLD_CYCLES(0), .REPEAT_EN(0), .REPEAT_CYCLES(REP)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
      .btn_state(b_state), .btn_down(b_down), .btn_up(b_up),
      .btn_hold(b_hold), .btn_repeat(b_rep)
   );

   // Reference model: level flips once STABLE consecutive synchronised samples disagree;
   // hold/repeat times are pure arithmetic on the press timestamp.
   bit [1:0] hist[$];
   int       t;
   bit       m_state[4];
   int       last_agree[4];
   int       press_t[4];

   always @(posedge clk) begin : predictor
      obs_t e;
      bit   s;
      bit   flip;
      int   d;
      if (!rst_n) begin
         hist.delete();
         t = 0;
         for (int l = 0; l < 4; l++) begin
            m_state[l]    = 1'b0;
            last_agree[l] = 0;
            press_t[l]    = 0;
         end
      end else begin
         t = t + 1;
         hist.push_back(btn_in);
         e = '0;
         for (int l = 0; l < 4; l++) begin
            flip = 1'b0;
            s = (t - SYNC >= 1) ? hist[t-SYNC-1][l%2] : 1'b0;
            if (s == m_state[l]) begin
               last_agree[l] = t;
            end else if (t - last_agree[l] >= STABLE) begin
               flip          = 1'b1;
               m_state[l]    = s;
               last_agree[l] = t;
               if (s) begin
                  e.dn[l]    = 1'b1;
                  press_t[l] = t;
               end else begin
                  e.up[l] = 1'b1;
               end
            end
            if (!flip && m_state[l] && m_hold[l] > 0) begin
               d = t - press_t[l];
               if (d == m_hold[l])
                  e.hd[l] = 1'b1;
               else if (m_rep_en[l] != 0 && d > m_hold[l] && (d - m_hold[l]) % REP == 0)
                  e.rp[l] = 1'b1;
            end
            e.st[l] = m_state[l];
         end
         exp_q.push_back(e);
      end
   end

   always @(negedge clk) begin : monitor
      obs_t a;
      obs_t e;
      a.st = {b_state, a_state};
      a.dn = {b_down, a_down};
      a.up = {b_up, a_up};
      a.hd = {b_hold, a_hold};
      a.rp = {b_rep, a_rep};
      if (!rst_n) begin
         exp_q.delete();
         n_chk++;
         if (a !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL reset_outputs t=%0t: got %h, required 0", $time, a);
         end
      end else if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_chk++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL cycle_outputs t=%0t: got st=%b dn=%b up=%b hd=%b rp=%b, required st=%b dn=%b up=%b hd=%b rp=%b",
                     $time, a.st, a.dn, a.up, a.hd, a.rp, e.st, e.dn, e.up, e.hd, e.rp);
         end else if (|{e.dn, e.up, e.hd, e.rp}) begin
            $display("t=%0t st=%b dn=%b up=%b hd=%b rp=%b ok", $time, a.st, a.dn, a.up, a.hd, a.rp);
         end
         for (int l = 0; l < 4; l++) begin
            if (a.dn[l] === 1'b1) c_dn[l]++;
            if (a.up[l] === 1'b1) c_up[l]++;
            if (a.hd[l] === 1'b1) c_hd[l]++;
            if (a.rp[l] === 1'b1) c_rp[l]++;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic check_cnt(input string name, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int b_dn[4], b_up[4], b_hd[4], b_rp[4];
      int run[2];
      rst_n  = 1'b0;
      btn_in = 2'b11;
      cyc(4);
      rst_n = 1'b1;
      b_dn = c_dn;
      cyc(8);
      check_cnt("reset_release_down0", c_dn[0] - b_dn[0], 1);
      check_cnt("reset_release_down1", c_dn[1] - b_dn[1], 1);
      btn_in = 2'b00;
      cyc(12);

      // Glitchy press on ch0 only.
      b_dn = c_dn; b_up = c_up;
      btn_in[0] = 1'b1; cyc(3);
      btn_in[0] = 1'b0; cyc(1);
      btn_in[0] = 1'b1; cyc(12);
      btn_in[0] = 1'b0; cyc(12);
      check_cnt("bounce_down0", c_dn[0] - b_dn[0], 1);
      check_cnt("bounce_ch1_quiet", (c_dn[1] - b_dn[1]) + (c_up[1] - b_up[1]), 0);

      // Long hold with auto-repeat.
      b_dn = c_dn; b_up = c_up; b_hd = c_hd; b_rp = c_rp;
      btn_in[0] = 1'b1; cyc(42);
      btn_in[0] = 1'b0; cyc(12);
      check_cnt("hold_count0", c_hd[0] - b_hd[0], 1);
      check_cnt("repeat_count0", c_rp[0] - b_rp[0], 4);
      check_cnt("hold_up0", c_up[0] - b_up[0], 1);

      // Release lands on the hold edge.
      b_up = c_up; b_hd = c_hd; b_rp = c_rp;
      btn_in[0] = 1'b1; cyc(20);
      btn_in[0] = 1'b0; cyc(12);
      check_cnt("race_hold0", c_hd[0] - b_hd[0], 0);
      check_cnt("race_up0", c_up[0] - b_up[0], 1);
      b_hd = c_hd;
      btn_in[0] = 1'b1; cyc(30);
      btn_in[0] = 1'b0; cyc(12);
      check_cnt("after_race_hold0", c_hd[0] - b_hd[0], 1);

      // Asynchronous reset part-way into a hold.
      btn_in[0] = 1'b1; cyc(16);
      b_up = c_up;
      rst_n = 1'b0; cyc(3);
      check_cnt("midreset_no_up0", c_up[0] - b_up[0], 0);
      rst_n = 1'b1;
      b_dn = c_dn;
      cyc(8);
      check_cnt("midreset_redown0", c_dn[0] - b_dn[0], 1);
      btn_in[0] = 1'b0; cyc(12);

      // Hold disabled bank: 100-cycle press.
      b_dn = c_dn; b_up = c_up; b_hd = c_hd; b_rp = c_rp;
      btn_in[0] = 1'b1; cyc(100);
      btn_in[0] = 1'b0; cyc(12);
      check_cnt("nohold_down", c_dn[2] - b_dn[2], 1);
      check_cnt("nohold_up", c_up[2] - b_up[2], 1);
      check_cnt("nohold_hold_rep", (c_hd[2] - b_hd[2]) + (c_rp[2] - b_rp[2]), 0);

      // Random runs: short bounces mixed with long presses.
      run[0] = 0;
      run[1] = 0;
      repeat (3000) begin
         for (int c = 0; c < 2; c++) begin
            if (run[c] == 0) begin
               btn_in[c] = 1'($urandom_range(0, 1));
               run[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                    : int'($urandom_range(1, 8));
            end
            run[c]--;
         end
         cyc(1);
      end
      btn_in = 2'b00;
      cyc(12);
      check_cnt("bank_b_never_holds", c_hd[2] + c_hd[3] + c_rp[2] + c_rp[3], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
